alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage directly downstream of the 64-bit ALU.
//  Captures ALU result S and flag word PSW through a valid/ready handshake and a 2-entry skid buffer.
//  Maintains the architectural PSW register. Feeds writeback with one-cycle latency and full throughput.
// PARAMETERS
//  DATA_W   64  width of ALU result
//  PSW_W    16  width of ALU flag word
//  TAG_W    4   destination tag carried alongside result (writeback register index)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-high reset
//  flush       in   1       synchronous discard of all buffered results
//  in_valid    in   1       ALU result present this cycle
//  in_ready    out  1       stage can accept; = !skid_valid (registered source, no comb path from out_ready)
//  in_result   in   DATA_W  ALU S
//  in_psw      in   PSW_W   ALU PSW
//  in_psw_we   in   1       this result updates the architectural PSW
//  in_tag      in   TAG_W   destination tag
//  out_valid   out  1       output register holds a result
//  out_ready   in   1       writeback consumes this cycle
//  out_result  out  DATA_W  buffered result
//  out_psw     out  PSW_W   PSW snapshot of buffered result
//  out_tag     out  TAG_W   tag of buffered result
//  psw_q       out  PSW_W   architectural PSW
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transfer): out_valid=0, skid_valid=0, out_result/out_psw/out_tag=0, psw_q=0;
//    in_ready=1 in first cycle after release. Buffered data lost.
//  - accept = in_valid & in_ready; drain = out_valid & out_ready.
//  - Entries: OUT (drives out_*), SKID (hidden). States by {out_valid,skid_valid}: EMPTY 00, ONE 10, FULL 11; 01 illegal.
//    EMPTY: accept -> ONE (input into OUT).
//    ONE:   accept&drain -> ONE (input into OUT); accept&!drain -> FULL (input into SKID);
//           !accept&drain -> EMPTY.
//    FULL:  in_ready=0; drain -> ONE (SKID moves to OUT); else hold.
//  - Latency: accepted on edge N, visible on out_* after edge N when OUT was free or draining.
//  - Throughput 1/cycle with out_ready tied high. No bubble on a single stall cycle.
//  - Ordering strictly FIFO; out_* held stable while out_valid & !out_ready.
//  - psw_q <= in_psw on accept & in_psw_we (at acceptance, not at drain). Accept without we leaves psw_q.
//  - flush (priority over everything but rst): next edge out_valid=0, skid_valid=0.
//    Same-cycle accept is dropped and does not update psw_q. psw_q otherwise retained.
//    Data regs are don't-care once invalid.
//  - No arithmetic on data; widths pass through unchanged.
// CONFIGURATION
//  ALU_RESULT_PERF_EN defined: adds outputs perf_accepts[31:0] and perf_stalls[31:0].
//    perf_accepts: +1 per accept.
//    perf_stalls: +1 per cycle with in_valid & !in_ready.
//    Both wrap modulo 2^32, reset to 0, unaffected by flush.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. Reset, then in_valid=1, in_result=64'h2000, in_psw_we=1, in_psw=16'h0001, out_ready=1
//     -> next cycle out_valid=1, out_result=64'h2000, psw_q=16'h0001.
//  2. Stream 4 results (1,2,3,4) with out_ready=1 each cycle
//     -> out_result 1,2,3,4 on consecutive cycles; in_ready never drops.
//  3. out_ready=0, push A then B -> in_ready=0 after B, out_result=A;
//     raise out_ready -> A then B drained in order, in_ready=1 after A drains.
//  4. FULL state, assert flush with in_valid=1, in_psw_we=1, in_psw=16'hBEEF
//     -> next cycle out_valid=0, in_ready=1, psw_q unchanged.
//  5. Push result with in_psw_we=0, in_psw=16'hFFFF -> psw_q keeps prior value.
//     Pulse rst mid-stall -> all outputs 0 immediately.
//  6. (ALU_RESULT_PERF_EN) 3 accepts plus 2 stalled cycles
//     -> perf_accepts=3, perf_stalls=2; counters preserved across flush.

Source files
------------

// File: rtl/alu_result_stage.sv
// Purpose: registered result stage after the 64-bit ALU; 2-entry skid buffer plus architectural PSW register.
// Latency: one cycle from accept to out_*; full throughput with out_ready held high.
// Backpressure: in_ready = !skid_valid (registered), so out_ready has no combinational path to in_ready.
// Optional feature: define ALU_RESULT_PERF_EN to add the perf_accepts / perf_stalls counters.
module alu_result_stage #(
    parameter int DATA_W = 64,
    parameter int PSW_W  = 16,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [PSW_W-1:0]  in_psw,
    input  logic              in_psw_we,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [PSW_W-1:0]  out_psw,
    output logic [TAG_W-1:0]  out_tag,
`ifdef ALU_RESULT_PERF_EN
    output logic [31:0]       perf_accepts,
    output logic [31:0]       perf_stalls,
`endif
    output logic [PSW_W-1:0]  psw_q
);

    // Encoding mirrors {out_valid, skid_valid}; 2'b01 is never entered.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic accept;
    logic drain;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid;

    logic [DATA_W-1:0] skid_result;
    logic [PSW_W-1:0]  skid_psw;
    logic [TAG_W-1:0]  skid_tag;

    assign out_valid = state_q[1];
    assign in_ready  = !state_q[0];
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and which entry loads from where; flush empties both and drops the accept.
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        load_out_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d       = ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // OUT entry: takes the new result directly, or promotes the skid entry when draining from FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_psw    <= '0;
            out_tag    <= '0;
        end else if (load_out_in) begin
            out_result <= in_result;
            out_psw    <= in_psw;
            out_tag    <= in_tag;
        end else if (load_out_skid) begin
            out_result <= skid_result;
            out_psw    <= skid_psw;
            out_tag    <= skid_tag;
        end
    end

    // SKID entry: catches the one result accepted while OUT is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_result <= '0;
            skid_psw    <= '0;
            skid_tag    <= '0;
        end else if (load_skid) begin
            skid_result <= in_result;
            skid_psw    <= in_psw;
            skid_tag    <= in_tag;
        end
    end

    // Architectural PSW updates at acceptance time, not when the result leaves the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psw_q <= '0;
        end else if (accept && in_psw_we && !flush) begin
            psw_q <= in_psw;
        end
    end

`ifdef ALU_RESULT_PERF_EN
    // Free-running event counters; wrap naturally and ignore flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_accepts <= '0;
            perf_stalls  <= '0;
        end else begin
            if (accept) begin
                perf_accepts <= perf_accepts + 32'd1;
            end
            if (in_valid && !in_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
